// File: rtl/mp_add_seq_if.sv
// Operand and result streams of the multi-precision add sequencer.
// master drives operands and accepts sums; slave is the sequencer.
interface mp_add_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_word;
  logic [WIDTH-1:0] b_word;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum_word;
  logic             out_last;

  modport master (
    output in_valid, a_word, b_word, out_ready,
    input  in_ready, out_valid, sum_word, out_last
  );

  modport slave (
    input  in_valid, a_word, b_word, out_ready,
    output in_ready, out_valid, sum_word, out_last
  );
endinterface

// File: rtl/mp_add_seq.sv
// Multi-precision add sequencer: streams words LSW first through one
// 16-bit add, chaining carry. MP_ADD_SUB_EN adds a `sub` port (A - B).
module mp_add_seq #(
  parameter int WIDTH     = 16,
  parameter int MAX_WORDS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] num_words,
  input  logic       cin_init,
`ifdef MP_ADD_SUB_EN
  input  logic       sub,
`endif
  mp_add_seq_if.slave bus,
  output logic       busy,
  output logic       done,
  output logic       cout_final,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam logic [3:0] MAXW = 4'(MAX_WORDS);

  state_t           state_q, state_d;
  logic [3:0]       len_q;
  logic [3:0]       cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;
  logic             ov_q;
  logic             last_q;
  logic             done_q;
  logic             err_q;
  logic             cout_q;

  logic             len_ok;
  logic             start_ok;
  logic             start_bad;
  logic             in_rdy;
  logic             accept;
  logic             last_acc;
  logic             out_hs;
  logic             init_c;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   add_r;

`ifdef MP_ADD_SUB_EN
  logic sub_q;
  assign b_eff  = sub_q ? ~bus.b_word : bus.b_word;
  assign init_c = sub | cin_init;
`else
  assign b_eff  = bus.b_word;
  assign init_c = cin_init;
`endif

  assign len_ok = (num_words != 4'd0) && (num_words <= MAXW);

  // Word adder: {cout,sum} = a + b + carry, modulo 2^(WIDTH+1).
  assign add_r = {1'b0, bus.a_word}
               + {1'b0, b_eff}
               + {{WIDTH{1'b0}}, carry_q};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake decode.
  always_comb begin
    state_d   = state_q;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    in_rdy    = 1'b0;
    accept    = 1'b0;
    last_acc  = 1'b0;
    out_hs    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            start_ok = 1'b1;
            state_d  = RUN;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      RUN: begin
        in_rdy   = !ov_q || bus.out_ready;
        accept   = bus.in_valid && in_rdy;
        last_acc = accept && (cnt_q == 4'(len_q - 4'd1));
        out_hs   = ov_q && bus.out_ready;
        if (last_acc) state_d = DRAIN;
      end
      DRAIN: begin
        out_hs = ov_q && bus.out_ready;
        if (out_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, result register, carry chain, pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      ov_q    <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cout_q  <= 1'b0;
`ifdef MP_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= start_bad;
      if (start_ok) begin
        len_q   <= num_words;
        cnt_q   <= '0;
        carry_q <= init_c;
        cout_q  <= 1'b0;
`ifdef MP_ADD_SUB_EN
        sub_q   <= sub;
`endif
      end
      if (accept) begin
        sum_q   <= add_r[WIDTH-1:0];
        carry_q <= add_r[WIDTH];
        ov_q    <= 1'b1;
        last_q  <= last_acc;
        cnt_q   <= cnt_q + 4'd1;
      end else if (out_hs) begin
        ov_q <= 1'b0;
      end
      if (state_q == DRAIN && out_hs) begin
        cout_q <= carry_q;
        done_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = ov_q;
  assign bus.sum_word  = sum_q;
  assign bus.out_last  = last_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign cout_final    = cout_q;
  assign err           = err_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed bench for mp_add_seq: vector table, backpressure,
// rejected starts, reset mid-operation, optional subtract.
module tb_mp_add_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] num_words;
  logic       cin_init;
  logic       busy;
  logic       done;
  logic       cout_final;
  logic       err;
`ifdef MP_ADD_SUB_EN
  logic       sub_r;
`endif

  int checks;
  int errors;

  mp_add_seq_if #(.WIDTH(16)) bus ();

  mp_add_seq #(
    .WIDTH(16),
    .MAX_WORDS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .num_words(num_words),
    .cin_init(cin_init),
`ifdef MP_ADD_SUB_EN
    .sub(sub_r),
`endif
    .bus(bus),
    .busy(busy),
    .done(done),
    .cout_final(cout_final),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               nw;
    logic             cin;
    logic [7:0][15:0] a;
    logic [7:0][15:0] b;
    logic [7:0][15:0] s;
    logic             co;
  } vec_t;

  vec_t vt[6];

  function automatic vec_t mkv(int nw, logic cin, logic [127:0] a,
                               logic [127:0] b, logic [127:0] s,
                               logic co);
    vec_t v;
    v.nw  = nw;
    v.cin = cin;
    v.a   = a;
    v.b   = b;
    v.s   = s;
    v.co  = co;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(vec_t v, int stall);
    int  ii;
    int  oo;
    int  sl;
    bit  fin;
    bit  stl;
    ii  = 0;
    oo  = 0;
    sl  = stall;
    fin = 1'b0;
    tick();
    start     = 1'b1;
    num_words = 4'(v.nw);
    cin_init  = v.cin;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
      bus.in_valid = (ii < v.nw);
      if (ii < v.nw) begin
        bus.a_word = v.a[ii];
        bus.b_word = v.b[ii];
      end
      stl = (sl > 0) && (oo == 0) && bus.out_valid;
      bus.out_ready = !stl;
      #1;
      if (cyc == 0) begin
        chk("in_ready_after_start", bus.in_ready, 1);
        chk("busy_run", busy, 1);
        chk("cout_cleared", cout_final, 0);
      end
      if (stl) begin
        chk("stall_hold_sum", bus.sum_word, v.s[0]);
        chk("stall_in_ready", bus.in_ready, 0);
        sl--;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("sum_word", bus.sum_word, v.s[oo]);
        chk("out_last", bus.out_last, (oo == v.nw - 1));
        oo++;
      end
      if (done) begin
        chk("words_out", oo, v.nw);
        chk("cout_final", cout_final, v.co);
        chk("done_cycle", cyc + 1, v.nw + 2 + stall);
        chk("no_err_with_done", err, 0);
        fin = 1'b1;
      end
      if (bus.in_valid && bus.in_ready) ii++;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    if (!fin) begin
      errors++;
      $display("FAIL op_timeout: got no done expected done");
    end else begin
      chk("done_pulse_end", done, 0);
      chk("busy_idle", busy, 0);
      chk("cout_held", cout_final, v.co);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    start         = 1'b0;
    num_words     = 4'd0;
    cin_init      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a_word    = '0;
    bus.b_word    = '0;
    bus.out_ready = 1'b1;
`ifdef MP_ADD_SUB_EN
    sub_r         = 1'b0;
`endif

    vt[0] = mkv(2, 1'b1, 128'hFF00, 128'h00FF,
                128'h0001_0000, 1'b0);
    vt[1] = mkv(1, 1'b0, 128'hFFFF, 128'h0001,
                128'h0000, 1'b1);
    vt[2] = mkv(3, 1'b1, 128'h03C3, 128'h00CF,
                128'h0000_0000_0493, 1'b0);
    vt[3] = mkv(4, 1'b0, 128'hFFFF_FFFF_FFFF_FFFF, 128'h0001,
                128'h0, 1'b1);
    vt[4] = mkv(3, 1'b0, 128'h8000_ABCD_1234, 128'h8000_5433_4321,
                128'h0001_0000_5555, 1'b1);
    vt[5] = mkv(8, 1'b1, 128'h0, {8{16'hFFFF}},
                128'h0, 1'b1);

    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sum", bus.sum_word, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cout", cout_final, 0);
    chk("rst_err", err, 0);

    for (int i = 0; i < 6; i++) run_op(vt[i], 0);

    run_op(vt[2], 5);

    for (int k = 0; k < 2; k++) begin
      tick();
      start     = 1'b1;
      num_words = (k == 0) ? 4'd0 : 4'd9;
      tick();
      start = 1'b0;
      chk("reject_err", err, 1);
      chk("reject_busy", busy, 0);
      chk("reject_no_done", done, 0);
      tick();
      chk("reject_err_pulse", err, 0);
      chk("reject_busy_after", busy, 0);
    end

    tick();
    start     = 1'b1;
    num_words = 4'd4;
    cin_init  = 1'b0;
    tick();
    start         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a_word    = 16'hFFFF;
    bus.b_word    = 16'h0001;
    bus.out_ready = 1'b1;
    tick();
    bus.b_word = 16'h0000;
    tick();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("mid_rst_in_ready", bus.in_ready, 0);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_sum", bus.sum_word, 0);
    chk("mid_rst_last", bus.out_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_cout", cout_final, 0);
    chk("mid_rst_err", err, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mid_rst_no_done", done, 0);
    end
    run_op(mkv(1, 1'b0, 128'h0001, 128'h0001, 128'h0002, 1'b0), 0);

`ifdef MP_ADD_SUB_EN
    sub_r = 1'b1;
    run_op(mkv(1, 1'b0, 128'h0005, 128'h0007, 128'hFFFE, 1'b0), 0);
    sub_r = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mp_add_seq.md
# mp_add_seq

Multi-precision add sequencer that sits directly upstream of the 16-bit ripple adder `adder16`. It streams operands word by word, least-significant word first, and drives the adder's `a`, `b` and `cin`. It registers each `sum` word, then chains the adder's `cout` into the next word's `cin`, so operands of 1..MAX_WORDS × 16 bits can be added on one `adder16` instance. Operands arrive over a valid/ready stream and results leave over a second valid/ready stream.

## Interface
- `WIDTH`, 16: word width; fixed to match `adder16`; other values are unsupported.
- `MAX_WORDS`, 8: maximum operand length in words; 2..15.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request to begin an operation; sampled only in IDLE.
- `num_words` input 4: operand length in words, sampled with `start`.
- `cin_init` input 1: carry into word 0, sampled with `start`.
- `in_valid` input 1: operand word pair valid.
- `in_ready` output 1: block accepts the operand pair this cycle.
- `a_word` input 16: operand A word.
- `b_word` input 16: operand B word.
- `out_valid` output 1: `sum_word` valid.
- `out_ready` input 1: downstream accepts `sum_word`.
- `sum_word` output 16: registered adder sum for the current word.
- `out_last` output 1: the current `sum_word` is the most-significant word.
- `busy` output 1: high whenever the FSM is not in IDLE.
- `done` output 1: one-cycle pulse when the last word is handed off.
- `cout_final` output 1: final carry; held from `done` until the next accepted `start`.
- `err` output 1: one-cycle pulse when a `start` is rejected.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE, `start`=1, `num_words` in 1..MAX_WORDS:
  - capture length; load carry := `cin_init`; word count := 0; clear `cout_final`.
  - go to RUN.
- IDLE, `start`=1, `num_words`=0 or >MAX_WORDS: pulse `err`; stay in IDLE.
- `start` outside IDLE is ignored (no `err`).
- RUN: `in_ready` = !`out_valid` || `out_ready` (one output register; a word is accepted in the same cycle the previous one drains).
- Accept (`in_valid` && `in_ready`):
  - drive `adder16` with `a_word`, `b_word`, carry.
  - register `sum_word` := sum; carry := cout; `out_valid` := 1.
  - `out_last` := (count == num_words-1); count += 1.
- On accepting the last word, go to DRAIN. `in_ready` is 0 in DRAIN and IDLE.
- DRAIN, on output handshake:
  - `cout_final` := carry; pulse `done`; clear `out_valid`.
  - go to IDLE.
- `out_valid` && !`out_ready`: `sum_word` and `out_last` hold stable.
- Arithmetic: per word `{cout,sum}` = a + b + cin, modulo 2^17. No saturation.
- Word count is 4 bits and never wraps, because `num_words` ≤ 15.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `sum_word`=0, `out_last`=0, `busy`=0, `done`=0, `cout_final`=0, `err`=0; FSM in IDLE; carry=0; count=0.
- `start` → `in_ready` high on the next cycle.
- Latency: operand accepted in cycle n → `sum_word` valid in cycle n+1.
- Throughput: 1 word/cycle while `out_ready` stays high.
- `done` asserts in the cycle after the last output handshake.
- Minimum operation with N words and no stalls: N+2 cycles from `start` to `done`.
- Reset asserted mid-operation takes effect at the next edge: partial results and carry are discarded and no `done` is produced.
- `err` and `done` never assert in the same cycle.

## Configuration
- `MP_ADD_SUB_EN` defined:
  - adds input port `sub` (1 bit), sampled with `start`.
  - with `sub`=1: B words are inverted before `adder16`; word-0 carry is forced to 1 regardless of `cin_init`.
  - result is A − B; `cout_final`=0 signals a borrow.
- `MP_ADD_SUB_EN` undefined: no `sub` port; add only.

## Test plan
- Two-word add with `cin_init`=1:
  - stimulus: A=0x0000_FF00, B=0x0000_00FF.
  - required: `sum_word` 0x0000 then 0x0001 with `out_last`=1; `cout_final`=0; `done` at cycle start+4.
- One-word overflow, `cin_init`=0:
  - stimulus: A=0xFFFF, B=0x0001.
  - required: `sum_word`=0x0000, `out_last`=1, `cout_final`=1.
- Backpressure on a 3-word add of 0x03C3+0x00CF (`cin_init`=1), `out_ready` low for 5 cycles after word 0:
  - required: `sum_word` holds 0x0493; `in_ready` stays 0 while stalled; no word is lost.
- Rejected starts:
  - stimulus: `start` with `num_words`=0, then with `num_words`=9 (MAX_WORDS=8).
  - required: `err` pulses each time; `busy` stays 0.
- Reset mid-operation:
  - stimulus: `rst` after word 1 of a 4-word add.
  - required: all outputs return to reset values the next cycle; no `done`; a following 1-word add of 0x0001+0x0001 gives 0x0002.
- With `MP_ADD_SUB_EN` defined:
  - stimulus: `sub`=1, A=0x0005, B=0x0007.
  - required: `sum_word`=0xFFFE, `cout_final`=0.
